// File: rtl/fpga_b_calc_top.sv
// FPGA-B top: FP32 multiply on board-link requests, ASCII-hex readout to an SPI OLED.
// Build option FP_ROUND_RNE_EN selects round-to-nearest-even (default: truncate).
`timescale 1ns/1ps
module fpga_b_calc_top #(
    parameter int MUL_LAT  = 3,
    parameter int SCLK_DIV = 4,
    parameter int PWR_DLY  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [103:0] i2c_in,
    output logic         CS,
    output logic         SDIN,
    output logic         SCLK,
    output logic         DC,
    output logic         RES,
    output logic         VBAT,
    output logic         VDD,
    output logic         FIN
);

`ifdef FP_ROUND_RNE_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif
    localparam logic [7:0] MUL_LAST = 8'(MUL_LAT - 2);
    localparam logic [7:0] PWR_LAST = 8'(PWR_DLY - 1);
    localparam logic [7:0] DIV_LAST = 8'(SCLK_DIV - 1);

    typedef enum logic [1:0] {
        C_IDLE = 2'b00,
        C_MUL  = 2'b01,
        C_FMT  = 2'b10,
        C_WAIT = 2'b11
    } cstate_t;

    typedef enum logic [2:0] {
        O_OFF, O_VDD, O_RES0, O_RES1, O_CMD, O_VBAT, O_READY, O_REF
    } ostate_t;

    cstate_t      current_state, next_state;
    ostate_t      o_state, o_next;
    logic [1:0]   operation, prev_op;
    logic [31:0]  operand_a, operand_b, a_q, b_q;
    logic [63:0]  last_pair;
    logic         en;
    logic [31:0]  product, ans, mul_res;
    logic [7:0]   mcnt;
    logic         multiplied_valid;
    logic [127:0] line0_reg, line1_reg;
    logic         refresh_req, ref_go, ref_done;
    logic         unused_bits;

    assign operation   = i2c_in[97:96];
    assign operand_a   = i2c_in[95:64];
    assign operand_b   = i2c_in[63:32];
    assign unused_bits = ^{i2c_in[103:98], i2c_in[31:0]};

    assign en = (operation == 2'b10) &&
                (({operand_a, operand_b} != last_pair) || (prev_op != 2'b10));

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    function automatic logic [63:0] hex8(input logic [31:0] v);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < 8; i++) s[8*i +: 8] = hexc(v[4*i +: 4]);
        return s;
    endfunction

    // FP32 multiply on the latched operands
    logic        m_sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0] m_prod;
    logic [22:0] m_frac;
    logic        m_g, m_r, m_s, m_up;
    logic [9:0]  m_exp;
    logic [23:0] m_rnd;

    always_comb begin
        m_sign = a_q[31] ^ b_q[31];
        a_nan  = (a_q[30:23] == 8'hFF) && (a_q[22:0] != 23'h0);
        b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'h0);
        a_inf  = (a_q[30:23] == 8'hFF) && (a_q[22:0] == 23'h0);
        b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'h0);
        a_zero = (a_q[30:23] == 8'h00);
        b_zero = (b_q[30:23] == 8'h00);
        m_prod = {24'h0, 1'b1, a_q[22:0]} * {24'h0, 1'b1, b_q[22:0]};
        m_exp  = {2'b0, a_q[30:23]} + {2'b0, b_q[30:23]};
        if (m_prod[47]) begin
            m_frac = m_prod[46:24];
            m_g    = m_prod[23];
            m_r    = m_prod[22];
            m_s    = |m_prod[21:0];
            m_exp  = m_exp + 10'd1;
        end else begin
            m_frac = m_prod[45:23];
            m_g    = m_prod[22];
            m_r    = m_prod[21];
            m_s    = |m_prod[20:0];
        end
        m_up  = RNE && m_g && (m_r || m_s || m_frac[0]);
        m_rnd = {1'b0, m_frac} + {23'h0, m_up};
        // rounding carry leaves a zero fraction one binade up
        if (m_rnd[23]) m_exp = m_exp + 10'd1;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
            mul_res = 32'h7FC00000;
        else if (a_inf || b_inf)
            mul_res = {m_sign, 8'hFF, 23'h0};
        else if (a_zero || b_zero)
            mul_res = {m_sign, 31'h0};
        else if (m_exp >= 10'd382)
            mul_res = {m_sign, 8'hFF, 23'h0};
        else if (m_exp <= 10'd127)
            mul_res = {m_sign, 31'h0};
        else
            mul_res = {m_sign, 8'(m_exp - 10'd127), m_rnd[22:0]};
    end

    always_comb begin
        next_state = current_state;
        case (current_state)
            C_IDLE:  if (en) next_state = C_MUL;
            C_MUL:   if (multiplied_valid) next_state = C_FMT;
            C_FMT:   next_state = C_WAIT;
            C_WAIT:  if (!FIN || (ref_done && !refresh_req))
                         next_state = C_IDLE;
            default: next_state = C_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            current_state    <= C_IDLE;
            prev_op          <= 2'b00;
            last_pair        <= '0;
            a_q              <= '0;
            b_q              <= '0;
            mcnt             <= '0;
            product          <= '0;
            ans              <= '0;
            multiplied_valid <= 1'b0;
            refresh_req      <= 1'b0;
            line0_reg        <= {16{8'h20}};
            line1_reg        <= {16{8'h20}};
        end else begin
            current_state    <= next_state;
            prev_op          <= operation;
            multiplied_valid <= 1'b0;
            if (current_state == C_IDLE && en) begin
                a_q       <= operand_a;
                b_q       <= operand_b;
                last_pair <= {operand_a, operand_b};
                mcnt      <= '0;
            end
            if (current_state == C_MUL) begin
                mcnt <= mcnt + 8'd1;
                if (mcnt == MUL_LAST) begin
                    product          <= mul_res;
                    multiplied_valid <= 1'b1;
                end
                if (multiplied_valid) ans <= product;
            end
            if (ref_go) refresh_req <= 1'b0;
            if (current_state == C_FMT) begin
                line0_reg   <= {hex8(a_q), hex8(b_q)};
                line1_reg   <= {"RES=", hex8(ans), "    "};
                refresh_req <= 1'b1;
            end
        end
    end

    // Panel power-up and refresh sequencer
    logic [7:0]   tmr;
    logic         tmr_done;
    logic [4:0]   idx, ridx;
    logic [255:0] lines;
    logic         sp_busy, sp_done, sp_start;
    logic [7:0]   sp_byte, sp_sh, sp_div;
    logic [3:0]   sp_half;

    assign tmr_done = (tmr == PWR_LAST);
    assign ref_go   = (o_state == O_READY) && refresh_req;
    assign ref_done = (o_state == O_REF) && sp_done && (idx == 5'd31);
    assign sp_start = ((o_state == O_CMD) || (o_state == O_REF)) &&
                      !sp_busy && !sp_done;
    assign lines    = {line0_reg, line1_reg};
    assign ridx     = 5'd31 - idx;

    always_comb begin
        sp_byte = lines[{ridx, 3'b000} +: 8];
        if (o_state == O_CMD) begin
            case (idx[1:0])
                2'd0:    sp_byte = 8'hAE;
                2'd1:    sp_byte = 8'h8D;
                2'd2:    sp_byte = 8'h14;
                default: sp_byte = 8'hAF;
            endcase
        end
    end

    always_comb begin
        o_next = o_state;
        CS     = 1'b1;
        DC     = 1'b0;
        RES    = 1'b1;
        VBAT   = 1'b1;
        VDD    = 1'b0;
        FIN    = 1'b0;
        case (o_state)
            O_OFF: begin
                VDD = 1'b1;
                if (tmr_done) o_next = O_VDD;
            end
            O_VDD:  if (tmr_done) o_next = O_RES0;
            O_RES0: begin
                RES = 1'b0;
                if (tmr_done) o_next = O_RES1;
            end
            O_RES1: if (tmr_done) o_next = O_CMD;
            O_CMD: begin
                CS = 1'b0;
                if (sp_done && idx == 5'd3) o_next = O_VBAT;
            end
            O_VBAT: begin
                VBAT = 1'b0;
                if (tmr_done) o_next = O_READY;
            end
            O_READY: begin
                VBAT = 1'b0;
                FIN  = 1'b1;
                if (refresh_req) o_next = O_REF;
            end
            O_REF: begin
                VBAT = 1'b0;
                FIN  = 1'b1;
                CS   = 1'b0;
                DC   = 1'b1;
                if (ref_done) o_next = O_READY;
            end
            default: o_next = O_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_state <= O_OFF;
            tmr     <= '0;
            idx     <= '0;
        end else begin
            o_state <= o_next;
            tmr     <= (o_next != o_state) ? 8'd0 : tmr + 8'd1;
            if (o_next != o_state) idx <= '0;
            else if (sp_done)      idx <= idx + 5'd1;
        end
    end

    // SCLK idles high; SDIN moves on the falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_busy <= 1'b0;
            sp_done <= 1'b0;
            sp_sh   <= '0;
            sp_div  <= '0;
            sp_half <= '0;
            SCLK    <= 1'b1;
            SDIN    <= 1'b0;
        end else begin
            sp_done <= 1'b0;
            if (sp_start) begin
                sp_busy <= 1'b1;
                sp_sh   <= sp_byte;
                sp_div  <= '0;
                sp_half <= '0;
            end else if (sp_busy) begin
                if (sp_div == DIV_LAST) begin
                    sp_div  <= '0;
                    sp_half <= sp_half + 4'd1;
                    if (!sp_half[0]) begin
                        SCLK  <= 1'b0;
                        SDIN  <= sp_sh[7];
                        sp_sh <= {sp_sh[6:0], 1'b0};
                    end else begin
                        SCLK <= 1'b1;
                        if (sp_half == 4'd15) begin
                            sp_busy <= 1'b0;
                            sp_done <= 1'b1;
                        end
                    end
                end else begin
                    sp_div <= sp_div + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fpga_b_calc_top.sv
// Directed bench for fpga_b_calc_top: vector table plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_fpga_b_calc_top;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [103:0] i2c_in = '0;
    logic         CS, SDIN, SCLK, DC, RES, VBAT, VDD, FIN;

    fpga_b_calc_top dut (
        .clk(clk), .rst(rst), .i2c_in(i2c_in),
        .CS(CS), .SDIN(SDIN), .SCLK(SCLK), .DC(DC),
        .RES(RES), .VBAT(VBAT), .VDD(VDD), .FIN(FIN)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int vcnt = 0;
    int vbad = 0;
    logic [7:0] cq[$];
    logic [7:0] dq[$];
    logic [7:0] sh = 8'h00;
    int bc = 0;

    // SPI receiver: panel samples on rising SCLK
    always @(posedge SCLK or posedge CS or negedge rst) begin
        if (rst !== 1'b1 || CS !== 1'b0) begin
            bc = 0;
        end else begin
            sh = {sh[6:0], SDIN};
            bc++;
            if (bc == 8) begin
                bc = 0;
                if (DC) dq.push_back(sh);
                else    cq.push_back(sh);
            end
        end
    end

    always @(posedge clk) begin
        if (rst === 1'b1 && dut.multiplied_valid === 1'b1) begin
            vcnt++;
            if (dut.current_state !== 2'b01) vbad++;
        end
    end

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] hx(input logic [31:0] v);
        string digits = "0123456789ABCDEF";
        logic [63:0] r = '0;
        for (int i = 7; i >= 0; i--)
            r = {r[55:0], digits.getc(int'(v[4*i +: 4]))};
        return r;
    endfunction

    task automatic wait_st(input logic [1:0] s, input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dut.current_state == s) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_fin(input int budget, output int ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (FIN === 1'b1) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic check_rx(input string nm, input logic [31:0] a, b, e);
        logic [255:0] rx = '0;
        chk32({nm, "_nbytes"}, dq.size(), 32);
        foreach (dq[i]) rx = {rx[247:0], dq[i]};
        chk128({nm, "_rx_line0"}, rx[255:128], {hx(a), hx(b)});
        chk128({nm, "_rx_line1"}, rx[127:0], {"RES=", hx(e), "    "});
    endtask

    task automatic run_mul(input logic [31:0] a, b, e, input string nm);
        int v0;
        int ok;
        v0 = vcnt;
        dq.delete();
        @(negedge clk);
        i2c_in = {6'h3F, 2'b10, a, b, 32'hDEADBEEF};
        wait_st(2'b01, 20, ok);
        chk32({nm, "_start"}, ok, 1);
        wait_st(2'b00, 4000, ok);
        chk32({nm, "_done"}, ok, 1);
        chk32({nm, "_product"}, dut.product, e);
        chk32({nm, "_ans"}, dut.ans, e);
        chk32({nm, "_valid_pulses"}, vcnt - v0, 1);
        chk128({nm, "_line1_reg"}, dut.line1_reg, {"RES=", hx(e), "    "});
        check_rx(nm, a, b, e);
    endtask

    task automatic check_reset(input string nm);
        chk1({nm, "_CS"}, CS, 1'b1);
        chk1({nm, "_SCLK"}, SCLK, 1'b1);
        chk1({nm, "_SDIN"}, SDIN, 1'b0);
        chk1({nm, "_DC"}, DC, 1'b0);
        chk1({nm, "_RES"}, RES, 1'b1);
        chk1({nm, "_VBAT"}, VBAT, 1'b1);
        chk1({nm, "_VDD"}, VDD, 1'b1);
        chk1({nm, "_FIN"}, FIN, 1'b0);
        chk32({nm, "_state"}, 32'(dut.current_state), 32'd0);
        chk32({nm, "_ans"}, dut.ans, 32'h0);
        chk32({nm, "_product"}, dut.product, 32'h0);
        chk1({nm, "_valid"}, dut.multiplied_valid, 1'b0);
        chk128({nm, "_line0"}, dut.line0_reg, {16{8'h20}});
        chk128({nm, "_line1"}, dut.line1_reg, {16{8'h20}});
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    vec_t tv[13];
    logic [31:0] rnd_exp;
    int ok;
    int v0;

    initial begin
`ifdef FP_ROUND_RNE_EN
        rnd_exp = 32'h3FC00002;
`else
        rnd_exp = 32'h3FC00001;
`endif
        tv[0]  = '{32'h40400000, 32'h40400000, 32'h41100000};
        tv[1]  = '{32'h00000000, 32'h40000000, 32'h00000000};
        tv[2]  = '{32'h40000000, 32'hBF800000, 32'hC0000000};
        tv[3]  = '{32'h40800000, 32'h3F000000, 32'h40000000};
        tv[4]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000};
        tv[5]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
        tv[6]  = '{32'h7F800001, 32'h3F800000, 32'h7FC00000};
        tv[7]  = '{32'hFF800000, 32'h40000000, 32'hFF800000};
        tv[8]  = '{32'hC0000000, 32'h00000000, 32'h80000000};
        tv[9]  = '{32'h00800000, 32'h00800000, 32'h00000000};
        tv[10] = '{32'h00400000, 32'h40000000, 32'h00000000};
        tv[11] = '{32'h3F800001, 32'h3FC00000, rnd_exp};
        tv[12] = '{32'h3F000000, 32'h3F000000, 32'h3E800000};

        #50;
        check_reset("rst");
        #50;
        rst = 1'b1;
        repeat (24) @(negedge clk);
        chk1("pwr_vdd_on", VDD, 1'b0);
        chk1("pwr_res_hi", RES, 1'b1);
        repeat (16) @(negedge clk);
        chk1("pwr_res_lo", RES, 1'b0);
        wait_fin(1000, ok);
        chk32("fin_rise", ok, 1);
        chk32("cmd_count", cq.size(), 4);
        chk32("cmd_bytes", {cq[0], cq[1], cq[2], cq[3]}, 32'hAE8D14AF);
        chk1("pwr_vbat", VBAT, 1'b0);
        chk1("pwr_res_done", RES, 1'b1);
        chk1("pwr_cs_idle", CS, 1'b1);
        chk32("no_data_at_init", dq.size(), 0);

        for (int i = 0; i < 13; i++)
            run_mul(tv[i].a, tv[i].b, tv[i].e, $sformatf("vec%0d", i));

        // op=00 is a no-op; results stay put
        v0 = vcnt;
        @(negedge clk);
        i2c_in[97:96] = 2'b00;
        repeat (200) @(negedge clk);
        chk32("noop_state", 32'(dut.current_state), 32'd0);
        chk32("noop_ans", dut.ans, 32'h3E800000);
        chk32("noop_valid", vcnt - v0, 0);
        chk1("fin_held", FIN, 1'b1);

        // same pair after a non-10 op is a fresh request; holding it runs once
        run_mul(32'h3F000000, 32'h3F000000, 32'h3E800000, "reissue");
        v0 = vcnt;
        repeat (3000) @(negedge clk);
        chk32("hold_valid", vcnt - v0, 0);
        chk32("hold_state", 32'(dut.current_state), 32'd0);

        // input change while busy is taken only after returning to IDLE
        @(negedge clk);
        i2c_in = {6'h0, 2'b10, 32'h40000000, 32'h40400000, 32'h0};
        wait_st(2'b11, 50, ok);
        chk32("busy_wait", ok, 1);
        i2c_in = {6'h0, 2'b10, 32'h40000000, 32'h40000000, 32'h0};
        wait_st(2'b00, 4000, ok);
        chk32("busy_done", ok, 1);
        chk32("busy_ans", dut.ans, 32'h40C00000);
        chk128("busy_line0", dut.line0_reg, {hx(32'h40000000), hx(32'h40400000)});
        wait_st(2'b01, 20, ok);
        chk32("next_start", ok, 1);
        wait_st(2'b11, 50, ok);
        chk32("next_wait", ok, 1);
        repeat (200) @(negedge clk);

        // reset in the middle of a refresh
        rst = 1'b0;
        #1;
        check_reset("midrst");
        repeat (3) @(negedge clk);
        dq.delete();
        cq.delete();
        rst = 1'b1;

        // request before FIN: refresh is deferred until power-up completes
        wait_st(2'b01, 20, ok);
        chk32("defer_start", ok, 1);
        wait_st(2'b00, 50, ok);
        chk32("defer_done", ok, 1);
        chk1("defer_fin_low", FIN, 1'b0);
        chk32("defer_product", dut.product, 32'h40800000);
        wait_fin(1000, ok);
        chk32("defer_fin", ok, 1);
        chk32("defer_cmds", cq.size(), 4);
        for (int i = 0; i < 4000 && dq.size() < 32; i++) @(negedge clk);
        check_rx("defer", 32'h40000000, 32'h40000000, 32'h40800000);
        chk32("defer_state", 32'(dut.current_state), 32'd0);
        chk32("valid_in_mul", vbad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
